// File: rtl/fp32_to_signed_fraction32.sv
// fp32_to_signed_fraction32: three-stage FP32 -> Q1.31 signed fraction converter
// with a valid/ready stream interface and full backpressure.
module fp32_to_signed_fraction32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_sat,
   output logic        out_invalid,
   output logic        out_underflow
);

   localparam int unsigned W      = 32;
   localparam int unsigned SIG_W  = 24;
   localparam int unsigned SHL_W  = 3;
   localparam int unsigned SHR_W  = 5;
   // Exponent at which the 24-bit significand lands unshifted in Q1.31.
   localparam logic [7:0]  E_ALIGN = 8'd119;

   typedef enum logic [2:0] {
      CL_NORM = 3'd0,
      CL_ZERO = 3'd1,
      CL_UFL  = 3'd2,
      CL_NAN  = 3'd3,
      CL_SAT  = 3'd4,
      CL_NEG1 = 3'd5
   } cls_e;

   // stage valids and advance enables
   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic en1, en2, en3;

   // S1 payload
   cls_e             cls1_q, cls1_d;
   logic             sign1_q, sign1_d;
   logic [SIG_W-1:0] sig1_q, sig1_d;
   logic             left1_q, left1_d;
   logic [SHL_W-1:0] shl1_q, shl1_d;
   logic [SHR_W-1:0] shr1_q, shr1_d;

   // S2 payload
   cls_e             cls2_q, cls2_d;
   logic             sign2_q, sign2_d;
   logic [W-1:0]     mag2_q, mag2_d;

   // S3 payload (drives outputs)
   logic [W-1:0]     data3_q, data3_d;
   logic             sat3_q, sat3_d;
   logic             inv3_q, inv3_d;
   logic             ufl3_q, ufl3_d;

   // classification results for the incoming word
   cls_e             cls_c;
   logic             left_c;
   logic [SHL_W-1:0] shl_c;
   logic [SHR_W-1:0] shr_c;
   logic [7:0]       rsh_c;
   logic [7:0]       exp_c;
   logic [22:0]      man_c;

   // S2 shifter and S3 result selection
   logic [W-1:0]     mag_c;
   logic [W-1:0]     res_data_c;
   logic             res_sat_c, res_inv_c, res_ufl_c;

   // Ready chain: a stage may load when empty or when its successor moves.
   always_comb begin
      en3      = ~v3_q | out_ready;
      en2      = ~v2_q | en3;
      en1      = ~v1_q | en2;
      in_ready = en1 | rst;
   end

   // Classify the input word and precompute the shift direction/amount.
   always_comb begin
      exp_c  = in_data[30:23];
      man_c  = in_data[22:0];
      cls_c  = CL_NORM;
      left_c = 1'b0;
      shl_c  = '0;
      shr_c  = '0;
      rsh_c  = E_ALIGN - exp_c;
      if (exp_c == 8'hFF) begin
         cls_c = (man_c != '0) ? CL_NAN : CL_SAT;
      end else if (exp_c == 8'h00) begin
         cls_c = (man_c != '0) ? CL_UFL : CL_ZERO;
      end else if (exp_c >= 8'd127) begin
         cls_c = (in_data[31] && exp_c == 8'd127 && man_c == '0) ? CL_NEG1 : CL_SAT;
      end else if (exp_c >= E_ALIGN) begin
         left_c = 1'b1;
         shl_c  = SHL_W'(exp_c - E_ALIGN);
      end else begin
         // Right shifts of 24 or more already clear the significand; clamp at 31.
         shr_c = (rsh_c >= 8'd31) ? SHR_W'(31) : rsh_c[SHR_W-1:0];
      end
   end

   // Barrel shift of the S1 significand into the 32-bit magnitude.
   always_comb begin
      mag_c = left1_q ? (W'(sig1_q) << shl1_q) : (W'(sig1_q) >> shr1_q);
   end

   // Negation and saturation selection from the S2 payload.
   always_comb begin
      res_data_c = '0;
      res_sat_c  = 1'b0;
      res_inv_c  = 1'b0;
      res_ufl_c  = 1'b0;
      case (cls2_q)
         CL_NORM: begin
            res_data_c = sign2_q ? (~mag2_q + W'(1)) : mag2_q;
            res_ufl_c  = (mag2_q == '0);
         end
         CL_UFL:  res_ufl_c = 1'b1;
         CL_NAN:  res_inv_c = 1'b1;
         CL_SAT: begin
            res_data_c = sign2_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            res_sat_c  = 1'b1;
         end
         CL_NEG1: res_data_c = 32'h8000_0000;
         default: res_data_c = '0;
      endcase
   end

   // Next-state for all pipeline registers: hold unless the stage is enabled.
   always_comb begin
      v1_d    = v1_q;
      cls1_d  = cls1_q;
      sign1_d = sign1_q;
      sig1_d  = sig1_q;
      left1_d = left1_q;
      shl1_d  = shl1_q;
      shr1_d  = shr1_q;
      v2_d    = v2_q;
      cls2_d  = cls2_q;
      sign2_d = sign2_q;
      mag2_d  = mag2_q;
      v3_d    = v3_q;
      data3_d = data3_q;
      sat3_d  = sat3_q;
      inv3_d  = inv3_q;
      ufl3_d  = ufl3_q;
      if (en1) begin
         v1_d    = in_valid;
         cls1_d  = cls_c;
         sign1_d = in_data[31];
         sig1_d  = {1'b1, in_data[22:0]};
         left1_d = left_c;
         shl1_d  = shl_c;
         shr1_d  = shr_c;
      end
      if (en2) begin
         v2_d    = v1_q;
         cls2_d  = cls1_q;
         sign2_d = sign1_q;
         mag2_d  = mag_c;
      end
      if (en3) begin
         v3_d    = v2_q;
         data3_d = res_data_c;
         sat3_d  = res_sat_c;
         inv3_d  = res_inv_c;
         ufl3_d  = res_ufl_c;
      end
   end

   // Pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         cls1_q  <= CL_ZERO;
         sign1_q <= 1'b0;
         sig1_q  <= '0;
         left1_q <= 1'b0;
         shl1_q  <= '0;
         shr1_q  <= '0;
         v2_q    <= 1'b0;
         cls2_q  <= CL_ZERO;
         sign2_q <= 1'b0;
         mag2_q  <= '0;
         v3_q    <= 1'b0;
         data3_q <= '0;
         sat3_q  <= 1'b0;
         inv3_q  <= 1'b0;
         ufl3_q  <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         cls1_q  <= cls1_d;
         sign1_q <= sign1_d;
         sig1_q  <= sig1_d;
         left1_q <= left1_d;
         shl1_q  <= shl1_d;
         shr1_q  <= shr1_d;
         v2_q    <= v2_d;
         cls2_q  <= cls2_d;
         sign2_q <= sign2_d;
         mag2_q  <= mag2_d;
         v3_q    <= v3_d;
         data3_q <= data3_d;
         sat3_q  <= sat3_d;
         inv3_q  <= inv3_d;
         ufl3_q  <= ufl3_d;
      end
   end

   assign out_valid     = v3_q;
   assign out_data      = data3_q;
   assign out_sat       = sat3_q;
   assign out_invalid   = inv3_q;
   assign out_underflow = ufl3_q;

endmodule

// File: tb/tb_fp32_to_signed_fraction32.sv
// Bench for fp32_to_signed_fraction32: directed vector table, backpressure,
// random stream against a reference model, and mid-stream reset.
module tb_fp32_to_signed_fraction32;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic        out_sat, out_invalid, out_underflow;
   logic [31:0] in_data, out_data;

   fp32_to_signed_fraction32 dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .out_invalid(out_invalid), .out_underflow(out_underflow)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct packed {
      logic [31:0] data;
      logic        sat;
      logic        inv;
      logic        ufl;
   } res_t;

   typedef struct {
      logic [31:0] din;
      logic [31:0] dout;
      logic        sat;
      logic        inv;
      logic        ufl;
   } vec_t;

   // Reference: value * 2^31 computed as sig * 2^(e-119) in 64-bit arithmetic.
   function automatic res_t ref_conv(input logic [31:0] x);
      res_t   r;
      int     e;
      int     sh;
      longint sig;
      longint mag;
      r   = '0;
      e   = int'(x[30:23]);
      sig = longint'({1'b1, x[22:0]});
      if (e == 255) begin
         if (x[22:0] != 23'd0) r.inv = 1'b1;
         else begin
            r.sat  = 1'b1;
            r.data = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end
      end else if (e == 0) begin
         r.ufl = (x[22:0] != 23'd0);
      end else if (e >= 127) begin
         r.data = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         r.sat  = !(x[31] && e == 127 && x[22:0] == 23'd0);
      end else begin
         sh = e - 119;
         if (sh >= 0) mag = sig << sh;
         else if (-sh >= 24) mag = 0;
         else mag = sig >> (-sh);
         r.data = x[31] ? 32'(-mag) : 32'(mag);
         r.ufl  = (mag == 0);
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_word();
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      s = 1'($urandom);
      m = 23'($urandom);
      case ($urandom % 8)
         0: begin e = 8'hFF; if ($urandom % 2 == 0) m = '0; end
         1: begin e = 8'h00; if ($urandom % 2 == 0) m = '0; end
         2: e = 8'($urandom_range(90, 100));
         3: begin e = 8'd127; if ($urandom % 2 == 0) m = '0; end
         default: e = 8'($urandom_range(100, 140));
      endcase
      return {s, e, m};
   endfunction

   // Scoreboard: push model result on accept, pop and compare on output handshake.
   res_t        exp_q[$];
   int          pushed = 0, popped = 0, dropped = 0;
   logic        prev_stall = 1'b0;
   logic [34:0] prev_out;

   always @(negedge clk) begin
      if (rst) begin
         dropped   += exp_q.size();
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", 64'({out_valid, out_data, out_sat, out_invalid, out_underflow}),
                64'({1'b1, prev_out}));
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_data, out_sat, out_invalid, out_underflow};
         if (out_valid && out_ready) begin
            chk("stream_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               chk("stream_out", 64'({out_data, out_sat, out_invalid, out_underflow}),
                   64'(exp_q.pop_front()));
               popped++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_conv(in_data));
            pushed++;
         end
      end
   end

   // Single word with exact latency: captured at edge 1, visible after edge 3.
   task automatic run_vec(input vec_t v, input string nm);
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = v.din;
      out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_accept"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_early"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk(nm, 64'({out_valid, out_data, out_sat, out_invalid, out_underflow}),
          64'({1'b1, v.dout, v.sat, v.inv, v.ufl}));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
      $fatal(1);
   end

   vec_t        vecs[21];
   logic [31:0] bp_words[6];

   initial begin
      int idx;
      int sent;
      int cyc;

      vecs[0]  = '{32'h3F00_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'hBF00_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{32'h3F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{32'hBF80_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'hC000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{32'h3000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'hB000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'h2F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{32'h3EAA_AAAB, 32'h2AAA_AAC0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{32'h3F7F_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{32'hFFC0_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{32'h0080_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{32'hBE80_0000, 32'hE000_0000, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{32'h3C00_0000, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{32'hBFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0};

      bp_words[0] = 32'h3E80_0000;
      bp_words[1] = 32'h3F00_0000;
      bp_words[2] = 32'hBF00_0000;
      bp_words[3] = 32'h3F40_0000;
      bp_words[4] = 32'h3000_0000;
      bp_words[5] = 32'hBF80_0000;

      // Reset state
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_outputs", 64'({out_valid, out_data, out_sat, out_invalid, out_underflow}), 64'd0);
      rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < 21; i++) run_vec(vecs[i], $sformatf("vec%0d_%h", i, vecs[i].din));

      // Backpressure: 6 words back-to-back, out_ready low for cycles 2..7
      idx = 0;
      for (int c = 0; c < 17; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 2 && c <= 7);
         in_valid  = (idx < 6);
         in_data   = (idx < 6) ? bp_words[idx] : 32'h0;
         @(negedge clk);
         if (c == 3)
            chk("bp_first_word", 64'({out_valid, out_data}), 64'({1'b1, 32'h2000_0000}));
         if (c >= 3 && c <= 7) chk($sformatf("bp_in_ready_low_c%0d", c), 64'(in_ready), 64'd0);
         if (c >= 8 && c <= 13) chk($sformatf("bp_drain_c%0d", c), 64'(out_valid), 64'd1);
         if (c == 14) chk("bp_drain_end", 64'(out_valid), 64'd0);
         if (in_valid && in_ready) idx++;
      end
      chk("bp_all_accepted", 64'(idx), 64'd6);
      in_valid = 1'b0;

      // Random stream with random backpressure
      sent = 0;
      cyc  = 0;
      while (sent < 10000 && cyc < 60000) begin
         @(posedge clk); #1;
         out_ready = ($urandom % 4) != 0;
         in_valid  = ($urandom % 4) != 0;
         in_data   = rand_word();
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      chk("rand_sent", 64'(sent), 64'd10000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 500) begin
         @(posedge clk); #1;
         out_ready = ($urandom % 2) != 0;
         cyc++;
      end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);

      // Mid-stream reset with 3 words held
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = bp_words[k];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("rst_full", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h3F80_0000;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("rst_cleared", 64'({out_valid, out_data, out_sat, out_invalid, out_underflow}), 64'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rst_no_stale_%0d", k), 64'(out_valid), 64'd0);
      end
      run_vec('{32'h3F40_0000, 32'h6000_0000, 1'b0, 1'b0, 1'b0}, "post_rst");
      repeat (2) @(posedge clk);
      #1;
      chk("balance", 64'(pushed), 64'(popped + dropped));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
